// File: rtl/timer_pkg.sv
// Shared constants and helpers for the timer counting path.
package timer_pkg;

  // Width of one BCD digit.
  localparam int DIGW = 4;

  // Largest supported number of digits; terminal-value vectors are
  // zero-extended to this many digits before indexing.
  localparam int MAX_NDIG = 8;

  // Terminal value of digit idx taken from a packed per-digit vector.
  function automatic logic [DIGW-1:0] digit_max(
    input logic [MAX_NDIG*DIGW-1:0] maxv,
    input int                       idx
  );
    return maxv[idx*DIGW +: DIGW];
  endfunction

  // Loaded digits above the terminal value are clamped to it.
  function automatic logic [DIGW-1:0] clamp_digit(
    input logic [DIGW-1:0] load_digit,
    input logic [DIGW-1:0] maxv
  );
    logic [DIGW-1:0] res;
    if (load_digit > maxv) begin
      res = maxv;
    end else begin
      res = load_digit;
    end
    return res;
  endfunction

endpackage

// File: rtl/digit_counter_chain_if.sv
// Control and result bundle of the multi-digit counter.
interface digit_counter_chain_if
  import timer_pkg::*;
#(
  parameter int NDIG = 4
) ();

  logic                   tick;
  logic                   up;
  logic                   load;
  logic [NDIG*DIGW-1:0]   load_val;
  logic [NDIG*DIGW-1:0]   cnt;
  logic                   term;
  logic                   at_zero;
  logic                   at_max;

  // Master drives the strobes and observes the count.
  modport master (
    output tick, up, load, load_val,
    input  cnt, term, at_zero, at_max
  );

  // Slave is the counter itself.
  modport slave (
    input  tick, up, load, load_val,
    output cnt, term, at_zero, at_max
  );

endinterface

// File: rtl/digit_counter_chain_cell.sv
// One BCD digit stage: holds its digit and steps it when enabled by the
// combinational chain in the top level.
module digit_cell
  import timer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            en_in,
  input  logic            up,
  input  logic            load,
  input  logic [DIGW-1:0] load_digit,
  input  logic [DIGW-1:0] maxv,
  output logic [DIGW-1:0] digit,
  output logic [DIGW-1:0] digit_nxt,
  output logic            at_max_d,
  output logic            at_zero_d,
  output logic            nxt_at_max,
  output logic            nxt_at_zero
);

  logic [DIGW-1:0] digit_q;
  logic [DIGW-1:0] digit_d;

  // Next digit value: load beats stepping; a step wraps between 0 and maxv.
  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = clamp_digit(load_digit, maxv);
    end else if (en_in) begin
      if (up) begin
        if (digit_q >= maxv) begin
          digit_d = {DIGW{1'b0}};
        end else begin
          digit_d = digit_q + 4'd1;
        end
      end else begin
        if (digit_q == 4'd0) begin
          digit_d = maxv;
        end else begin
          digit_d = digit_q - 4'd1;
        end
      end
    end else begin
      digit_d = digit_q;
    end
  end

  // Digit register; every stage shares the one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q <= {DIGW{1'b0}};
    end else begin
      digit_q <= digit_d;
    end
  end

  // at_max_d/at_zero_d decode the held digit and feed the carry/borrow
  // chain; the nxt_* decodes feed the registered flags in the top level.
  assign digit       = digit_q;
  assign digit_nxt   = digit_d;
  assign at_max_d    = (digit_q == maxv);
  assign at_zero_d   = (digit_q == 4'd0);
  assign nxt_at_max  = (digit_d == maxv);
  assign nxt_at_zero = (digit_d == 4'd0);

endmodule

// File: rtl/digit_counter_chain.sv
// Synchronous NDIG-digit modulo counter with up/down, load, wrap or hold
// at terminal, and a registered one-cycle terminal pulse.
module digit_counter_chain
  import timer_pkg::*;
#(
  parameter int                   NDIG = 4,
  parameter logic [NDIG*DIGW-1:0] MAXV = 16'h5959,
  parameter bit                   WRAP = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  digit_counter_chain_if.slave  bus
);

  localparam logic [MAX_NDIG*DIGW-1:0] MAXV_EXT = (MAX_NDIG*DIGW)'(MAXV);

  logic [NDIG*DIGW-1:0] cnt_q;
  logic [NDIG*DIGW-1:0] cnt_nxt_s;
  logic [NDIG-1:0]      en_in_s;
  logic [NDIG-1:0]      dig_at_max_s;
  logic [NDIG-1:0]      dig_at_zero_s;
  logic [NDIG-1:0]      nxt_at_max_s;
  logic [NDIG-1:0]      nxt_at_zero_s;
  logic [NDIG:0]        chain_max_s;
  logic [NDIG:0]        chain_zero_s;
  logic                 terminal_s;
  logic                 step_s;

  logic term_q;
  logic term_d;
  logic at_zero_q;
  logic at_zero_d;
  logic at_max_q;
  logic at_max_d;

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    localparam logic [DIGW-1:0] DMAX = digit_max(MAXV_EXT, g);

    digit_cell u_cell (
      .clk        (clk),
      .rst        (rst),
      .en_in      (en_in_s[g]),
      .up         (bus.up),
      .load       (bus.load),
      .load_digit (bus.load_val[g*DIGW +: DIGW]),
      .maxv       (DMAX),
      .digit      (cnt_q[g*DIGW +: DIGW]),
      .digit_nxt  (cnt_nxt_s[g*DIGW +: DIGW]),
      .at_max_d   (dig_at_max_s[g]),
      .at_zero_d  (dig_at_zero_s[g]),
      .nxt_at_max (nxt_at_max_s[g]),
      .nxt_at_zero(nxt_at_zero_s[g])
    );
  end

  // Carry/borrow chain: digit i may step when all lower digits are at
  // their terminal (up) or at zero (down); hold mode freezes the terminal.
  always_comb begin
    chain_max_s  = {(NDIG+1){1'b0}};
    chain_zero_s = {(NDIG+1){1'b0}};
    en_in_s      = {NDIG{1'b0}};
    chain_max_s[0]  = 1'b1;
    chain_zero_s[0] = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      chain_max_s[i+1]  = chain_max_s[i] & dig_at_max_s[i];
      chain_zero_s[i+1] = chain_zero_s[i] & dig_at_zero_s[i];
    end
    if (bus.up) begin
      terminal_s = bus.tick & ~bus.load & chain_max_s[NDIG];
    end else begin
      terminal_s = bus.tick & ~bus.load & chain_zero_s[NDIG];
    end
    step_s = bus.tick & ~bus.load & ~(terminal_s & ~WRAP);
    for (int i = 0; i < NDIG; i++) begin
      if (bus.up) begin
        en_in_s[i] = step_s & chain_max_s[i];
      end else begin
        en_in_s[i] = step_s & chain_zero_s[i];
      end
    end
  end

  // Status flags decoded from the next count so they line up with cnt.
  always_comb begin
    term_d    = terminal_s;
    at_zero_d = &nxt_at_zero_s;
    at_max_d  = &nxt_at_max_s;
  end

  // Status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      term_q    <= 1'b0;
      at_zero_q <= 1'b1;
      at_max_q  <= 1'b0;
    end else begin
      term_q    <= term_d;
      at_zero_q <= at_zero_d;
      at_max_q  <= at_max_d;
    end
  end

  assign bus.cnt     = cnt_q;
  assign bus.term    = term_q;
  assign bus.at_zero = at_zero_q;
  assign bus.at_max  = at_max_q;

endmodule

// File: tb/tb_digit_counter_chain.sv
// Bench for digit_counter_chain: directed table plus randomized traffic
// against a mixed-radix integer model; one wrap and one hold instance.
module tb_digit_counter_chain;

  localparam int TOTAL = 3600;

  logic        clk = 1'b0;
  logic        rst_s;
  logic        tick_s;
  logic        up_s;
  logic        load_s;
  logic [15:0] lv_s;

  int checks = 0;
  int failures = 0;

  digit_counter_chain_if #(.NDIG(4)) bus_w ();
  digit_counter_chain_if #(.NDIG(4)) bus_h ();

  assign bus_w.tick = tick_s;  assign bus_h.tick = tick_s;
  assign bus_w.up = up_s;      assign bus_h.up = up_s;
  assign bus_w.load = load_s;  assign bus_h.load = load_s;
  assign bus_w.load_val = lv_s; assign bus_h.load_val = lv_s;

  digit_counter_chain #(.NDIG(4), .MAXV(16'h5959), .WRAP(1'b1)) dut_w (
    .clk(clk), .rst(rst_s), .bus(bus_w));
  digit_counter_chain #(.NDIG(4), .MAXV(16'h5959), .WRAP(1'b0)) dut_h (
    .clk(clk), .rst(rst_s), .bus(bus_h));

  always #5 clk = ~clk;

  typedef struct {
    logic        r, l, t, u;
    logic [15:0] lv;
    logic [15:0] exp_w;
    logic        tw;
    logic [15:0] exp_h;
    logic        th;
  } vec_t;

  vec_t tbl[19];

  function automatic int dmax(input int i);
    logic [15:0] mv;
    mv = 16'h5959;
    return int'(mv[4*i +: 4]);
  endfunction

  function automatic int bcd_to_val(input logic [15:0] b);
    int v, w;
    v = 0; w = 1;
    for (int i = 0; i < 4; i++) begin
      v += int'(b[4*i +: 4]) * w;
      w *= dmax(i) + 1;
    end
    return v;
  endfunction

  function automatic logic [15:0] val_to_bcd(input int v);
    logic [15:0] b;
    int rem;
    rem = v;
    b = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      b[4*i +: 4] = 4'(rem % (dmax(i) + 1));
      rem = rem / (dmax(i) + 1);
    end
    return b;
  endfunction

  function automatic logic [15:0] clamp_bcd(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++)
      if (int'(b[4*i +: 4]) > dmax(i)) r[4*i +: 4] = 4'(dmax(i));
    return r;
  endfunction

  task automatic model_step(input int v, input bit wrap, input bit r, input bit l,
                            input bit t, input bit u, input logic [15:0] lv,
                            output int nv, output bit tm);
    nv = v; tm = 1'b0;
    if (r) nv = 0;
    else if (l) nv = bcd_to_val(clamp_bcd(lv));
    else if (t) begin
      if (u) begin
        if (v == TOTAL - 1) begin tm = 1'b1; nv = wrap ? 0 : v; end
        else nv = v + 1;
      end else begin
        if (v == 0) begin tm = 1'b1; nv = wrap ? TOTAL - 1 : v; end
        else nv = v - 1;
      end
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit l, input bit t, input bit u, input logic [15:0] lv);
    rst_s = r; load_s = l; tick_s = t; up_s = u; lv_s = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic check_both(input string tag, input logic [15:0] ew, input bit tw,
                            input logic [15:0] eh, input bit th);
    check({tag, " cnt_w"}, 32'(bus_w.cnt), 32'(ew));
    check({tag, " term_w"}, 32'(bus_w.term), 32'(tw));
    check({tag, " zero_w"}, 32'(bus_w.at_zero), 32'(ew == 16'h0000));
    check({tag, " max_w"}, 32'(bus_w.at_max), 32'(ew == 16'h5959));
    check({tag, " cnt_h"}, 32'(bus_h.cnt), 32'(eh));
    check({tag, " term_h"}, 32'(bus_h.term), 32'(th));
    check({tag, " zero_h"}, 32'(bus_h.at_zero), 32'(eh == 16'h0000));
    check({tag, " max_h"}, 32'(bus_h.at_max), 32'(eh == 16'h5959));
  endtask

  initial begin
    int mw, mh, nw, nh;
    bit tw, th, r, l, t, u;
    logic [15:0] lv;

    rst_s = 1'b1; load_s = 1'b0; tick_s = 1'b0; up_s = 1'b1; lv_s = 16'h0000;

    //          r     l     t     u     lv        exp_w     tw    exp_h     th
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0958, 16'h0958, 1'b0, 16'h0958, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0959, 1'b0, 16'h0959, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h1000, 1'b0, 16'h1000, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h5959, 16'h5959, 1'b0, 16'h5959, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1, 16'h5959, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h5959, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0001, 1'b0, 16'h5959, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h1000, 16'h1000, 1'b0, 16'h1000, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0959, 1'b0, 16'h0959, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h5959, 1'b1, 16'h0000, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'hFF9A, 16'h5959, 1'b0, 16'h5959, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1, 16'h5959, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0001, 1'b0, 16'h5959, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0002, 1'b0, 16'h5959, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, 16'h1234, 1'b0, 16'h1234, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h1233, 1'b0, 16'h1233, 1'b0};
    tbl[18] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h5959, 16'h0000, 1'b0, 16'h0000, 1'b0};

    for (int k = 0; k < 19; k++) begin
      drive(tbl[k].r, tbl[k].l, tbl[k].t, tbl[k].u, tbl[k].lv);
      check_both($sformatf("vec%0d", k), tbl[k].exp_w, tbl[k].tw, tbl[k].exp_h, tbl[k].th);
    end

    // Idle after reset: the count must not move for ten cycles.
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
      check_both("idle", 16'h0000, 1'b0, 16'h0000, 1'b0);
    end

    // Randomized traffic against the integer model.
    mw = 0; mh = 0;
    for (int k = 0; k < 3000; k++) begin
      r  = ($urandom_range(0, 99) == 0);
      l  = ($urandom_range(0, 7) == 0);
      t  = ($urandom_range(0, 3) != 0);
      u  = ($urandom_range(0, 5) != 0) ^ (k >= 1500);
      lv = 16'($urandom);
      if ($urandom_range(0, 3) == 0) lv = (k % 2 == 0) ? 16'h5959 : 16'h0000;
      model_step(mw, 1'b1, r, l, t, u, lv, nw, tw);
      model_step(mh, 1'b0, r, l, t, u, lv, nh, th);
      mw = nw; mh = nh;
      drive(r, l, t, u, lv);
      check_both("rand", val_to_bcd(mw), tw, val_to_bcd(mh), th);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/digit_counter_chain.md
# digit_counter_chain

Parametrised, fully synchronous multi-digit modulo counter for the timer path, successor to the single mod-10 ripple stage. Counts NDIG digits, each with its own modulus up to 10, on one clock gated by a tick enable, so no digit stage clocks another. Adds up/down counting, parallel load, wrap or stop-at-terminal mode, and a one-cycle terminal pulse for cascading or alarm logic. Sits between the 1 Hz tick generator and the BCD display drivers.

## Interface
- NDIG, 4: number of digits, 1..8.
- MAXV, 16'h5959: per-digit terminal value, 4 bits per digit, digit 0 in bits [3:0]. Each value 1..9. The default gives mm:ss.
- WRAP, 1: 1 = wrap at terminal; 0 = hold at terminal.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset rst, synchronous, active-high.
- tick  in  1  count enable, sampled every clk; a one-cycle pulse per count.
- up  in  1  direction, sampled together with tick: 1 = up, 0 = down.
- load  in  1  parallel load strobe.
- load_val  in  4*NDIG  BCD value to load, digit 0 in the LSBs.
- cnt  out  4*NDIG  current count, BCD per digit, registered.
- term  out  1  one-cycle pulse on a terminal event, registered.
- at_zero  out  1  high while every digit equals 0, registered.
- at_max  out  1  high while every digit equals its MAXV, registered.

## Operation
- Priority per edge: rst, then load, then tick. Otherwise all registers hold.
- rst: cnt=0, term=0, at_zero=1, at_max=0.
- load: digit i takes min(load_val[i], MAXV[i]), so illegal digits clamp to MAXV. term=0. tick is ignored in the same cycle.
- Up count on tick:
  - Digit 0 always steps.
  - Digit i>0 steps only when every lower digit is at MAXV.
  - A stepping digit at MAXV goes to 0; otherwise it adds 1.
- Down count on tick:
  - Digit i>0 steps only when every lower digit is 0.
  - A stepping digit at 0 goes to MAXV; otherwise it subtracts 1.
- Terminal event: a tick arrives while the whole count is all-MAXV (up) or all-zero (down).
  - WRAP=1: the count wraps (all-MAXV to all-zero, or all-zero to all-MAXV) and term=1 for exactly one cycle.
  - WRAP=0: cnt holds and term=1 for one cycle on every such tick.
- The enable chain is combinational across digits within one cycle. No digit register is clocked by another digit.
- at_zero and at_max are decoded from the next-state value and registered, so they always match cnt.
- A direction change between ticks is legal and takes effect on the next tick.

## Timing
- Latency: tick or load at edge N is visible on cnt, term, at_zero and at_max after edge N.
- term is high for exactly the one cycle in which cnt shows the post-event value (or the held value when WRAP=0).
- Back-to-back ticks every cycle are supported at full rate.
- rst mid-count clears on the next edge regardless of tick or load.
- No combinational path from any input to any output.

## Structure
- Package timer_pkg holds:
  - DIGW=4.
  - Function digit_max(MAXV,i) returning the 4-bit terminal value of digit i.
  - Function clamp_digit for load clamping.
- Sub-module digit_cell, one instance per digit:
  - Inputs: en_in, up, load, load_digit, maxv.
  - Outputs: digit register, at_max_d, at_zero_d.
  - The top level ANDs the lower digits' at_max_d/at_zero_d to form en_in for each digit.
- Top level generates NDIG digit_cells and owns term, at_zero and at_max.

## Test plan
- Reset and hold: assert rst for 1 cycle with tick=1 → cnt=16'h0000, term=0, at_zero=1. With tick=0 for 10 cycles, cnt stays 0000.
- Up cascade with defaults: load 16'h0958, then 2 ticks with up=1 → cnt=0959, then 1000. term stays 0.
- Wrap: load 16'h5959, 1 tick up → cnt=0000 and term=1 for exactly one cycle; the next cycle term=0.
- Down with borrow: load 16'h1000, 1 tick with up=0 → cnt=0959. Load 0000, 1 tick down → cnt=5959 and term=1.
- Hold mode: WRAP=0, load 5959, 3 ticks up → cnt stays 5959 and term pulses on each tick. load_val=16'hFF9A → cnt=5959 (clamped).
- Simultaneous events: load and tick in the same cycle → only the load happens. rst with load=1 → cnt=0000.
